// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: output registers, debounced buttons with sticky press flags,
// and a latched PS/2 key code, all decoded from the top-of-address-space window.
module mmio_io_hub #(
    parameter int WIDTH           = 16,
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_OUT         = 2,
    parameter int NUM_IN          = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic                     we_i,
    input  logic                     rd_en_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [NUM_IN-1:0]        btn_raw_i,
    input  logic [7:0]               key_code_i,
    input  logic                     key_valid_i,
    output logic                     io_sel_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [NUM_OUT*WIDTH-1:0] out_data_o,
    output logic [NUM_IN-1:0]        btn_level_o
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_IN-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? {NUM_IN{1'b1}} : {NUM_IN{1'b0}};
    localparam logic [5:0]        OFF_FLAGS = 6'h20;
    localparam logic [5:0]        OFF_LEVEL = 6'h21;
    localparam logic [5:0]        OFF_KEY   = 6'h22;

    logic [WIDTH-1:0]  out_q [NUM_OUT];
    logic [WIDTH-1:0]  rd_data_q, rd_word;
    logic [NUM_IN-1:0] sync1_q, sync2_q, synced;
    logic [NUM_IN-1:0] level_q, level_d;
    logic [NUM_IN-1:0] flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];
    logic [7:0]        key_q;
    logic              key_new_q, key_new_d;
    logic [5:0]        off;
    logic              wr_hit, rd_hit;
    logic              unused_addr;

    assign io_sel_o    = (addr_i[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11);
    assign off         = addr_i[5:0];
    assign wr_hit      = we_i & io_sel_o;
    assign rd_hit      = rd_en_i & io_sel_o;
    assign unused_addr = ^addr_i;
    assign synced      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Counter only advances while the synced pin disagrees with the debounced level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (synced[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TC) begin
                level_d[i] = synced[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // A new press wins over a clearing read in the same cycle.
    always_comb begin
        flag_d = flag_q;
        if (rd_hit && off == OFF_FLAGS) begin
            flag_d = '0;
        end
        flag_d = flag_d | (level_d & ~level_q);
    end

    always_comb begin
        key_new_d = key_new_q;
        if (rd_hit && off == OFF_KEY) begin
            key_new_d = 1'b0;
        end
        if (key_valid_i) begin
            key_new_d = 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (off == 6'(k)) begin
                rd_word = out_q[k];
            end
        end
        if (off == OFF_FLAGS) begin
            rd_word[NUM_IN-1:0] = flag_q;
        end else if (off == OFF_LEVEL) begin
            rd_word[NUM_IN-1:0] = level_q;
        end else if (off == OFF_KEY) begin
            rd_word[15]  = key_new_q;
            rd_word[7:0] = key_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= '0;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
            rd_data_q <= '0;
            sync1_q   <= SYNC_IDLE;
            sync2_q   <= SYNC_IDLE;
            level_q   <= '0;
            flag_q    <= '0;
            key_q     <= '0;
            key_new_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_hit && off == 6'(k)) begin
                    out_q[k] <= wdata_i;
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (rd_hit) begin
                rd_data_q <= rd_word;
            end
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            flag_q    <= flag_d;
            key_new_q <= key_new_d;
            if (key_valid_i) begin
                key_q <= key_code_i;
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign out_data_o[k*WIDTH +: WIDTH] = out_q[k];
    end

    assign rd_data_o   = rd_data_q;
    assign btn_level_o = level_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub with a short debounce window.
module tb_mmio_io_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  addr;
    logic        we;
    logic        rd_en;
    logic [15:0] wdata;
    logic [2:0]  btn_raw;
    logic [7:0]  key_code;
    logic        key_valid;
    logic        io_sel;
    logic [15:0] rd_data;
    logic [31:0] out_data;
    logic [2:0]  btn_level;

    int checks = 0;
    int errors = 0;
    logic [15:0] rd;

    mmio_io_hub #(
        .WIDTH(16), .ADDR_WIDTH(10), .NUM_OUT(2), .NUM_IN(3),
        .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)
    ) dut (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .we_i(we), .rd_en_i(rd_en),
        .wdata_i(wdata), .btn_raw_i(btn_raw), .key_code_i(key_code), .key_valid_i(key_valid),
        .io_sel_o(io_sel), .rd_data_o(rd_data), .out_data_o(out_data), .btn_level_o(btn_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [15:0] d);
        addr = a; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_raw = 3'b111;
        cyc(3);
        reset = 1'b0;
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        checks++; if (btn_level !== 3'b000) begin errors++; $display("FAIL reset_btn_level: got %b want 000", btn_level); end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_flags: got %h want 0000", rd); end
        bus_read(10'h322, rd);
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_key: got %h want 0000", rd); end
    endtask

    task automatic test_write();
        bus_write(10'h301, 16'h0042);
        checks++; if (out_data[31:16] !== 16'h0042) begin errors++; $display("FAIL write_reg1: got %h want 0042", out_data[31:16]); end
        bus_write(10'h300, 16'h1234);
        checks++; if (out_data !== 32'h0042_1234) begin errors++; $display("FAIL write_reg0: got %h want 00421234", out_data); end
        addr = 10'h101;
        #1;
        checks++; if (io_sel !== 1'b0) begin errors++; $display("FAIL io_sel_outside: got %b want 0", io_sel); end
        bus_write(10'h101, 16'h1111);
        bus_write(10'h002, 16'h2222);
        checks++; if (out_data !== 32'h0042_1234) begin errors++; $display("FAIL write_outside: got %h want 00421234", out_data); end
        addr = 10'h3C0;
        #1;
        checks++; if (io_sel !== 1'b1) begin errors++; $display("FAIL io_sel_inside: got %b want 1", io_sel); end
        bus_read(10'h301, rd);
        checks++; if (rd !== 16'h0042) begin errors++; $display("FAIL read_reg1: got %h want 0042", rd); end
        addr = 10'h300;
        cyc(2);
        checks++; if (rd_data !== 16'h0042) begin errors++; $display("FAIL rd_hold: got %h want 0042", rd_data); end
        bus_write(10'h302, 16'h5555);
        bus_read(10'h302, rd);
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0000", rd); end
        checks++; if (out_data !== 32'h0042_1234) begin errors++; $display("FAIL unmapped_write: got %h want 00421234", out_data); end
    endtask

    task automatic test_glitch();
        btn_raw = 3'b101;
        cyc(3);
        btn_raw = 3'b111;
        cyc(8);
        checks++; if (btn_level !== 3'b000) begin errors++; $display("FAIL glitch_level: got %b want 000", btn_level); end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL glitch_flag: got %h want 0000", rd); end
    endtask

    task automatic test_debounce();
        btn_raw = 3'b101;
        for (int n = 1; n <= 6; n++) begin
            cyc();
            checks++;
            if (btn_level[1] !== (n == 6)) begin
                errors++; $display("FAIL debounce_edge%0d: got %b want %b", n, btn_level[1], (n == 6));
            end
        end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL flag_read1: got %h want 0002", rd); end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL flag_read2: got %h want 0000", rd); end
        btn_raw = 3'b111;
        cyc(8);
        checks++; if (btn_level !== 3'b000) begin errors++; $display("FAIL release_level: got %b want 000", btn_level); end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL release_flag: got %h want 0000", rd); end
    endtask

    task automatic test_clear_collision();
        btn_raw = 3'b110;
        cyc(5);
        checks++; if (btn_level[0] !== 1'b0) begin errors++; $display("FAIL pre_rise: got %b want 0", btn_level[0]); end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL collide_read: got %h want 0000", rd); end
        checks++; if (btn_level !== 3'b001) begin errors++; $display("FAIL collide_level: got %b want 001", btn_level); end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL collide_flag: got %h want 0001", rd); end
        bus_read(10'h321, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL level_read: got %h want 0001", rd); end
    endtask

    task automatic test_key();
        key_code = 8'h1C; key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        bus_read(10'h322, rd);
        checks++; if (rd !== 16'h801C) begin errors++; $display("FAIL key_new: got %h want 801c", rd); end
        bus_read(10'h322, rd);
        checks++; if (rd !== 16'h001C) begin errors++; $display("FAIL key_cleared: got %h want 001c", rd); end
        key_code = 8'h5A; key_valid = 1'b1;
        bus_read(10'h322, rd);
        key_valid = 1'b0;
        checks++; if (rd !== 16'h001C) begin errors++; $display("FAIL key_collide_prior: got %h want 001c", rd); end
        bus_read(10'h322, rd);
        checks++; if (rd !== 16'h805A) begin errors++; $display("FAIL key_collide_new: got %h want 805a", rd); end
    endtask

    task automatic test_back_to_back();
        addr = 10'h300; wdata = 16'hBEEF; we = 1'b1; rd_en = 1'b1;
        cyc();
        we = 1'b0; rd_en = 1'b0;
        checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL rw_read: got %h want 1234", rd_data); end
        checks++; if (out_data !== 32'h0042_BEEF) begin errors++; $display("FAIL rw_write: got %h want 0042beef", out_data); end
    endtask

    task automatic test_reset_mid();
        btn_raw = 3'b111;
        cyc(8);
        btn_raw = 3'b011;
        cyc(4);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (btn_level !== 3'b000) begin errors++; $display("FAIL midreset_level: got %b want 000", btn_level); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midreset_out: got %h want 00000000", out_data); end
        for (int n = 1; n <= 6; n++) begin
            cyc();
            checks++;
            if (btn_level[2] !== (n == 6)) begin
                errors++; $display("FAIL midreset_edge%0d: got %b want %b", n, btn_level[2], (n == 6));
            end
        end
        bus_read(10'h320, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL midreset_flag: got %h want 0004", rd); end
    endtask

    initial begin
        reset = 1'b1; addr = '0; we = 1'b0; rd_en = 1'b0; wdata = '0;
        btn_raw = 3'b111; key_code = '0; key_valid = 1'b0;
        test_reset();
        test_write();
        test_glitch();
        test_debounce();
        test_clear_collision();
        test_key();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
